// File: rtl/pll_supervisor_pkg.sv
// pll_supervisor_pkg: shared FSM state encodings for the PLL supervisor
package pll_supervisor_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        S_HOLD      = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RUN       = 3'd3,
        S_FAULT     = 3'd4
    } state_t;

endpackage

// File: rtl/pll_supervisor_if.sv
// pll_supervisor_if: PLL lock/restart inputs and sequencing/status outputs of the supervisor
// loss_count exists only when PLL_SUPERVISOR_LOSS_CNT_EN is defined
interface pll_supervisor_if;
    import pll_supervisor_pkg::*;

    logic               pll_lock;
    logic               restart;
    logic               pll_resetb;
    logic               sys_reset;
    logic               pll_ready;
    logic               fault;
    logic [1:0]         retry_count;
    logic [STATE_W-1:0] state;
`ifdef PLL_SUPERVISOR_LOSS_CNT_EN
    logic [7:0]         loss_count;
`endif

    modport slave (
        input  pll_lock, restart,
`ifdef PLL_SUPERVISOR_LOSS_CNT_EN
        output loss_count,
`endif
        output pll_resetb, sys_reset, pll_ready, fault, retry_count, state
    );

    modport master (
        output pll_lock, restart,
`ifdef PLL_SUPERVISOR_LOSS_CNT_EN
        input  loss_count,
`endif
        input  pll_resetb, sys_reset, pll_ready, fault, retry_count, state
    );

endinterface

// File: rtl/pll_supervisor_sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous bit, async active-high reset to 0
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_q;

    // first flop may go metastable; second gives it a full cycle to settle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_q    <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_q    <= r_meta;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/pll_supervisor.sv
// pll_supervisor: sequences PLL reset, qualifies lock, gates downstream reset, retries and faults
// Optional lock-loss counter output enabled by defining PLL_SUPERVISOR_LOSS_CNT_EN
module pll_supervisor
    import pll_supervisor_pkg::*;
#(
    parameter int RESET_HOLD_CYCLES   = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 12000,
    parameter int LOCK_STABLE_CYCLES  = 256,
    parameter int MAX_RETRIES         = 3,
    parameter int CNT_W               = 24
) (
    input  logic             clk,
    input  logic             reset,
    pll_supervisor_if.slave  bus
);

    localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(RESET_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LD   = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] ST_LD   = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [1:0]       RTY_MAX = 2'(MAX_RETRIES);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_retry;
    logic             r_pll_resetb;
    logic             r_sys_reset;
    logic             r_ready;
    logic             r_fault;

    state_t           w_nxt;
    logic [CNT_W-1:0] w_cnt;
    logic [1:0]       w_retry;
    logic [1:0]       w_retry_inc;
    logic             w_lock_s;

    sync_2ff u_lock_sync (
        .clk (clk),
        .rst (reset),
        .i_d (bus.pll_lock),
        .o_q (w_lock_s)
    );

    assign w_retry_inc = (r_retry == RTY_MAX) ? r_retry : r_retry + 2'd1;

    // next state, shared down-counter and retry bookkeeping; restart overrides everything
    always_comb begin
        w_nxt   = r_state;
        w_cnt   = r_cnt - CNT_W'(1);
        w_retry = r_retry;
        if (bus.restart) begin
            w_nxt   = S_HOLD;
            w_cnt   = HOLD_LD;
            w_retry = '0;
        end else begin
            case (r_state)
                S_HOLD: begin
                    if (r_cnt == '0) begin
                        w_nxt = S_WAIT_LOCK;
                        w_cnt = TO_LD;
                    end
                end
                S_WAIT_LOCK: begin
                    if (w_lock_s) begin
                        w_nxt = S_STABLE;
                        w_cnt = ST_LD;
                    end else if (r_cnt == '0) begin
                        w_retry = w_retry_inc;
                        w_nxt   = (w_retry_inc == RTY_MAX) ? S_FAULT : S_HOLD;
                        w_cnt   = HOLD_LD;
                    end
                end
                S_STABLE: begin
                    if (!w_lock_s) begin
                        w_nxt = S_WAIT_LOCK;
                        w_cnt = TO_LD;
                    end else if (r_cnt == '0) begin
                        w_nxt = S_RUN;
                    end
                end
                S_RUN: begin
                    w_cnt = r_cnt;
                    if (!w_lock_s) begin
                        w_nxt   = S_HOLD;
                        w_cnt   = HOLD_LD;
                        w_retry = '0;
                    end
                end
                S_FAULT: w_cnt = r_cnt;
                default: begin
                    w_nxt = S_HOLD;
                    w_cnt = HOLD_LD;
                end
            endcase
        end
    end

    // FSM state plus outputs registered from the next state so they change on the same edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_HOLD;
            r_cnt        <= HOLD_LD;
            r_retry      <= '0;
            r_pll_resetb <= 1'b0;
            r_sys_reset  <= 1'b1;
            r_ready      <= 1'b0;
            r_fault      <= 1'b0;
        end else begin
            r_state      <= w_nxt;
            r_cnt        <= w_cnt;
            r_retry      <= w_retry;
            r_pll_resetb <= w_nxt inside {S_WAIT_LOCK, S_STABLE, S_RUN};
            r_sys_reset  <= w_nxt != S_RUN;
            r_ready      <= w_nxt == S_RUN;
            r_fault      <= w_nxt == S_FAULT;
        end
    end

    assign bus.pll_resetb  = r_pll_resetb;
    assign bus.sys_reset   = r_sys_reset;
    assign bus.pll_ready   = r_ready;
    assign bus.fault       = r_fault;
    assign bus.retry_count = r_retry;
    assign bus.state       = r_state;

`ifdef PLL_SUPERVISOR_LOSS_CNT_EN
    logic [7:0] r_loss;

    // saturating count of lock losses while running; survives restart, cleared only by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_loss <= '0;
        else if (r_state == S_RUN && !w_lock_s && !bus.restart && r_loss != 8'hFF)
            r_loss <= r_loss + 8'd1;
    end

    assign bus.loss_count = r_loss;
`endif

endmodule

// File: tb/tb_pll_supervisor.sv
// tb_pll_supervisor: directed stimulus with a dwell-time reference model checked every cycle
module tb_pll_supervisor;
    import pll_supervisor_pkg::*;

    localparam int H  = 4;
    localparam int T  = 20;
    localparam int S  = 8;
    localparam int MR = 2;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    pll_supervisor_if bus ();

    pll_supervisor #(
        .RESET_HOLD_CYCLES   (H),
        .LOCK_TIMEOUT_CYCLES (T),
        .LOCK_STABLE_CYCLES  (S),
        .MAX_RETRIES         (MR),
        .CNT_W               (24)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int m_st    = 0;
    int m_dwell = 0;
    int m_retry = 0;
    int m_loss  = 0;
    bit [1:0] m_sync = 2'b00;
    bit m_ls;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_state(input int s, input int budget, input string name);
        int k = 0;
        while (bus.state !== 3'(s) && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(name, 32'(bus.state), s);
    endtask

    // reference model: tracks time already spent in each state rather than a reload counter
    initial forever begin
        @(posedge clk or posedge reset);
        if (reset) begin
            m_st = 0; m_dwell = 0; m_retry = 0; m_loss = 0; m_sync = 2'b00;
        end else begin
            m_ls   = m_sync[1];
            m_sync = {m_sync[0], bus.pll_lock};
            if (bus.restart) begin
                m_st = 0; m_dwell = 0; m_retry = 0;
            end else begin
                case (m_st)
                    0: if (m_dwell == H - 1) begin m_st = 1; m_dwell = 0; end
                       else m_dwell++;
                    1: if (m_ls) begin m_st = 2; m_dwell = 0; end
                       else if (m_dwell == T - 1) begin
                           m_retry = (m_retry < MR) ? m_retry + 1 : MR;
                           m_st    = (m_retry == MR) ? 4 : 0;
                           m_dwell = 0;
                       end else m_dwell++;
                    2: if (!m_ls) begin m_st = 1; m_dwell = 0; end
                       else if (m_dwell == S - 1) begin m_st = 3; m_dwell = 0; end
                       else m_dwell++;
                    3: if (!m_ls) begin
                           m_st = 0; m_dwell = 0; m_retry = 0;
                           m_loss = (m_loss < 255) ? m_loss + 1 : 255;
                       end
                    default: ;
                endcase
            end
        end
    end

    // per-cycle comparison of every output against the model
    initial forever begin
        @(negedge clk);
        chk("m_state",      32'(bus.state),       m_st);
        chk("m_pll_resetb", 32'(bus.pll_resetb),  32'(m_st >= 1 && m_st <= 3));
        chk("m_sys_reset",  32'(bus.sys_reset),   32'(m_st != 3));
        chk("m_pll_ready",  32'(bus.pll_ready),   32'(m_st == 3));
        chk("m_fault",      32'(bus.fault),       32'(m_st == 4));
        chk("m_retry",      32'(bus.retry_count), m_retry);
`ifdef PLL_SUPERVISOR_LOSS_CNT_EN
        chk("m_loss",       32'(bus.loss_count),  m_loss);
`endif
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.pll_lock = 1'b0;
        bus.restart  = 1'b0;
        step(2);
        chk("rst_sys_reset", 32'(bus.sys_reset), 1);
        chk("rst_state", 32'(bus.state), S_HOLD);
        reset = 1'b0;

        // normal bring-up: hold 4, lock 10 cycles after release, stable 8, run
        step(3);  chk("t1_resetb_held", 32'(bus.pll_resetb), 0);
        step(1);  chk("t1_resetb_rel", 32'(bus.pll_resetb), 1);
        step(10); bus.pll_lock = 1'b1;
        step(2);  chk("t1_still_wait", 32'(bus.state), S_WAIT_LOCK);
        step(1);  chk("t1_stable", 32'(bus.state), S_STABLE);
        step(7);  chk("t1_sysrst_pre", 32'(bus.sys_reset), 1);
        step(1);  chk("t1_sysrst_run", 32'(bus.sys_reset), 0);
        chk("t1_ready", 32'(bus.pll_ready), 1);

        // never locks: two timeouts then FAULT, sticky, cleared by restart
        bus.pll_lock = 1'b0;
        reset = 1'b1; step(1); reset = 1'b0;
        step(4);  chk("t2_wait1", 32'(bus.state), S_WAIT_LOCK);
        step(19); chk("t2_wait1_end", 32'(bus.state), S_WAIT_LOCK);
        step(1);  chk("t2_hold2", 32'(bus.state), S_HOLD);
        chk("t2_retry1", 32'(bus.retry_count), 1);
        step(4);  chk("t2_wait2", 32'(bus.state), S_WAIT_LOCK);
        step(19); chk("t2_wait2_end", 32'(bus.state), S_WAIT_LOCK);
        step(1);  chk("t2_fault_state", 32'(bus.state), S_FAULT);
        chk("t2_retry2", 32'(bus.retry_count), 2);
        chk("t2_fault", 32'(bus.fault), 1);
        chk("t2_fault_resetb", 32'(bus.pll_resetb), 0);
        step(1000); chk("t2_fault_sticky", 32'(bus.fault), 1);
        bus.restart = 1'b1;
        step(1);  chk("t2_restart_hold", 32'(bus.state), S_HOLD);
        chk("t2_restart_retry", 32'(bus.retry_count), 0);
        chk("t2_restart_fault", 32'(bus.fault), 0);
        step(5);  chk("t2_restart_held", 32'(bus.state), S_HOLD);
        bus.restart = 1'b0;

        // one timeout, then lock_s lands exactly on the next timeout cycle: lock wins
        wait_state(S_WAIT_LOCK, 10, "t5_wait_a");
        step(19); chk("t5_wait_a_end", 32'(bus.state), S_WAIT_LOCK);
        step(1);  chk("t5_retry1", 32'(bus.retry_count), 1);
        wait_state(S_WAIT_LOCK, 10, "t5_wait_b");
        step(17); bus.pll_lock = 1'b1;
        step(2);  chk("t5_pre_edge", 32'(bus.state), S_WAIT_LOCK);
        step(1);  chk("t5_lock_wins", 32'(bus.state), S_STABLE);
        chk("t5_retry_kept", 32'(bus.retry_count), 1);

        // one-cycle lock glitch mid-STABLE restarts qualification, retries untouched
        step(3); bus.pll_lock = 1'b0;
        step(1); bus.pll_lock = 1'b1;
        wait_state(S_WAIT_LOCK, 5, "t3_back_wait");
        chk("t3_retry_kept", 32'(bus.retry_count), 1);
        wait_state(S_STABLE, 5, "t3_restable");
        step(7); chk("t3_full_stable", 32'(bus.state), S_STABLE);
        step(1); chk("t3_run", 32'(bus.state), S_RUN);

        // lock loss in RUN: reset downstream within three cycles, retries cleared
        step(3); bus.pll_lock = 1'b0;
        step(2); chk("t4_ready_still", 32'(bus.pll_ready), 1);
        step(1); chk("t4_sysrst", 32'(bus.sys_reset), 1);
        chk("t4_ready_low", 32'(bus.pll_ready), 0);
        chk("t4_hold", 32'(bus.state), S_HOLD);
        chk("t4_retry_clr", 32'(bus.retry_count), 0);
`ifdef PLL_SUPERVISOR_LOSS_CNT_EN
        chk("t4_loss1", 32'(bus.loss_count), 1);
        for (int i = 0; i < 300; i++) begin
            bus.pll_lock = 1'b1;
            wait_state(S_RUN, 40, "t4_rep_run");
            bus.pll_lock = 1'b0;
            wait_state(S_HOLD, 5, "t4_rep_hold");
        end
        chk("t4_loss_sat", 32'(bus.loss_count), 255);
`endif

        // async reset between edges mid-STABLE takes effect without a clock
        bus.pll_lock = 1'b1;
        wait_state(S_STABLE, 20, "t6_stable");
        step(2);
        #2 reset = 1'b1;
        #1;
        chk("t6_sysrst_async", 32'(bus.sys_reset), 1);
        chk("t6_resetb_async", 32'(bus.pll_resetb), 0);
        chk("t6_state_async", 32'(bus.state), S_HOLD);
        @(negedge clk); reset = 1'b0;
        step(4); chk("t6_rewait", 32'(bus.state), S_WAIT_LOCK);
        step(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
